// File: rtl/pc_pkg.sv
// Shared types and helpers for the program counter unit.
package pc_pkg;

  localparam int unsigned ADDR_W_DEF = 32;

  typedef enum logic {RUN, HALTED} pc_state_e;

  typedef logic [ADDR_W_DEF-1:0] addr_t;

  // Clears the low log2(bytes) bits; bytes must be a power of two.
  function automatic logic [63:0] align_addr(input logic [63:0] a,
                                             input int unsigned bytes);
    return a & ~(64'(bytes) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return address stack; a push when full overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_push_addr,
  output logic [ADDR_W-1:0] o_top,
  output logic              o_empty
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]     r_ptr;
  logic [PW:0]       r_cnt;
  logic              w_pop;
  logic [PW-1:0]     w_ptr_pop;

  assign o_empty   = (r_cnt == '0);
  assign w_pop     = i_pop && !o_empty;
  assign w_ptr_pop = w_pop ? r_ptr - 1'b1 : r_ptr;
  assign o_top     = r_mem[r_ptr - 1'b1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else begin
      r_ptr <= i_push ? w_ptr_pop + 1'b1 : w_ptr_pop;
      if (w_pop && !i_push)
        r_cnt <= r_cnt - 1'b1;
      else if (i_push && !w_pop && r_cnt != (PW+1)'(RAS_DEPTH))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Pop-then-push lands the new entry in the slot just vacated.
  always_ff @(posedge clk) begin
    if (i_push)
      r_mem[w_ptr_pop] <= i_push_addr;
  end

endmodule

// File: rtl/pc_unit.sv
// Front-end program counter: increment, redirect, trap/eret, halt/resume, EPC.
// Optional return address stack enabled with macro PC_RAS_EN.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter logic [31:0] RESET_VEC   = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
  parameter int unsigned INSTR_BYTES = 4,
  parameter int unsigned RAS_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              halt,
  input  logic              resume,
  input  logic              stallPC,
  input  logic              redirectValid,
  input  logic [ADDR_W-1:0] redirectAddr,
  input  logic              trap,
  input  logic              eret,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] currAddr,
  output logic [ADDR_W-1:0] epc,
  output logic              halted
);

  pc_state_e         r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_pc, w_pc_nxt;
  logic [ADDR_W-1:0] r_epc, w_epc_nxt;
  logic [ADDR_W-1:0] w_redir_al, w_target, w_seq;
  logic              w_redir_take;

  assign w_seq      = r_pc + ADDR_W'(INSTR_BYTES);
  assign w_redir_al = ADDR_W'(align_addr(64'(redirectAddr), INSTR_BYTES));
  // Redirect only takes effect in RUN when no trap/eret outranks it.
  assign w_redir_take = (r_state == RUN) && redirectValid && !trap && !eret;

`ifdef PC_RAS_EN
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_empty;

  pc_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_redir_take && call),
    .i_pop       (w_redir_take && ret),
    .i_push_addr (w_seq),
    .o_top       (w_ras_top),
    .o_empty     (w_ras_empty)
  );

  assign w_target = (ret && !w_ras_empty) ? w_ras_top : w_redir_al;
`else
  logic w_unused_ras;
  assign w_unused_ras = ^{call, ret};
  assign w_target     = w_redir_al;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_pc    <= ADDR_W'(RESET_VEC);
      r_epc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_epc   <= w_epc_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    unique case (r_state)
      RUN: begin
        if (trap) begin
          w_pc_nxt  = ADDR_W'(TRAP_VEC);
          w_epc_nxt = r_pc;
        end else if (eret) begin
          w_pc_nxt = r_epc;
        end else if (redirectValid) begin
          w_pc_nxt = w_target;
        end else if (halt) begin
          w_state_nxt = HALTED;
        end else if (!stallPC) begin
          w_pc_nxt = w_seq;
        end
      end
      HALTED: begin
        if (trap) begin
          w_pc_nxt    = ADDR_W'(TRAP_VEC);
          w_epc_nxt   = r_pc;
          w_state_nxt = RUN;
        end else if (resume) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign currAddr = r_pc;
  assign epc      = r_epc;
  assign halted   = (r_state == HALTED);

endmodule

// File: tb/tb_pc_unit.sv
// Randomised + directed bench for pc_unit against a behavioural model.
module tb_pc_unit;

  localparam logic [31:0] TRAP = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        halt, resume, stallPC, redirectValid, trap, eret, call, ret;
  logic [31:0] redirectAddr;
  logic [31:0] currAddr, epc;
  logic        halted;

  int errs = 0;
  int nchk = 0;

  logic [31:0] m_pc, m_epc;
  logic        m_halt;
  logic [31:0] m_ras [$];

  pc_unit dut (
    .clk(clk), .rst(rst), .halt(halt), .resume(resume), .stallPC(stallPC),
    .redirectValid(redirectValid), .redirectAddr(redirectAddr), .trap(trap),
    .eret(eret), .call(call), .ret(ret), .currAddr(currAddr), .epc(epc),
    .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic model_step;
    logic [31:0] tgt;
    if (!m_halt) begin
      if (trap) begin
        m_epc = m_pc;
        m_pc  = TRAP;
      end else if (eret) begin
        m_pc = m_epc;
      end else if (redirectValid) begin
        tgt = {redirectAddr[31:2], 2'b00};
`ifdef PC_RAS_EN
        if (ret && m_ras.size() > 0) tgt = m_ras.pop_back();
        if (call) begin
          m_ras.push_back(m_pc + 32'd4);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
`endif
        m_pc = tgt;
      end else if (halt) begin
        m_halt = 1'b1;
      end else if (!stallPC) begin
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (trap) begin
        m_epc  = m_pc;
        m_pc   = TRAP;
        m_halt = 1'b0;
      end else if (resume) begin
        m_halt = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, currAddr, m_pc);
    chk({tag, ".epc"}, epc, m_epc);
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, m_halt});
  endtask

  task automatic cyc(input logic h, input logic rs, input logic s, input logic rv,
                     input logic [31:0] ra, input logic t, input logic e,
                     input logic c, input logic rt, input string tag);
    halt = h; resume = rs; stallPC = s; redirectValid = rv; redirectAddr = ra;
    trap = t; eret = e; call = c; ret = rt;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(0, 0, 0, 0, 32'd0, 0, 0, 0, 0, tag);
  endtask

  task automatic jump(input logic [31:0] a);
    cyc(0, 0, 0, 1, a, 0, 0, 0, 0, "jump");
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    m_pc = 32'd0; m_epc = 32'd0; m_halt = 1'b0;
    m_ras.delete();
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    halt = 0; resume = 0; stallPC = 0; redirectValid = 0; redirectAddr = 0;
    trap = 0; eret = 0; call = 0; ret = 0;
    rst = 1'b1;
    #2;
    do_reset("reset");
    chk("tp_reset_pc", currAddr, 32'd0);

    for (int i = 0; i < 3; i++) idle("free");
    chk("tp_free3", currAddr, 32'd12);

    jump(32'h20);
    cyc(0, 0, 1, 0, 32'd0, 0, 0, 0, 0, "stall1");
    cyc(0, 0, 1, 0, 32'd0, 0, 0, 0, 0, "stall2");
    chk("tp_stall_hold", currAddr, 32'h20);
    cyc(0, 0, 1, 1, 32'h103, 0, 0, 0, 0, "redir_align");
    chk("tp_redir_align", currAddr, 32'h100);

    jump(32'h40);
    cyc(1, 0, 0, 0, 32'd0, 0, 0, 0, 0, "halt");
    chk("tp_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, i[0], 32'h300, 0, i[1], 0, 0, "halt_hold");
    chk("tp_halt_pc", currAddr, 32'h40);
    cyc(1, 1, 0, 0, 32'd0, 0, 0, 0, 0, "resume");
    chk("tp_resume_pc", currAddr, 32'h40);
    idle("post_resume");
    chk("tp_resume_inc", currAddr, 32'h44);

    jump(32'h80);
    cyc(1, 0, 1, 0, 32'd0, 1, 1, 0, 0, "trap_stall");
    chk("tp_trap_pc", currAddr, 32'h100);
    chk("tp_trap_epc", epc, 32'h80);
    idle("t1");
    idle("t2");
    cyc(1, 0, 1, 1, 32'h500, 0, 1, 0, 0, "eret");
    chk("tp_eret", currAddr, 32'h80);

    jump(32'hFFFF_FFFC);
    idle("wrap");
    chk("tp_wrap", currAddr, 32'h0);

    cyc(1, 0, 0, 0, 32'd0, 0, 0, 0, 0, "halt2");
    cyc(0, 0, 0, 0, 32'd0, 1, 0, 0, 0, "trap_in_halt");
    cyc(1, 0, 0, 0, 32'd0, 0, 0, 0, 0, "halt3");
    idle("h");
    halt = 0;
    @(negedge clk);
    do_reset("reset_mid_halt");
    chk("tp_reset_halted", {31'd0, halted}, 32'd0);

`ifdef PC_RAS_EN
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 32'h200, 0, 0, 1, 0, "call");
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 32'h500, 0, 0, 0, 1, "ret");
    chk("tp_ras_empty_ret", currAddr, 32'h500);
    cyc(0, 0, 0, 1, 32'h600, 0, 0, 1, 0, "call_a");
    cyc(0, 0, 0, 1, 32'h700, 0, 0, 1, 1, "call_ret");
    cyc(0, 0, 0, 1, 32'h900, 0, 0, 0, 1, "ret_b");
    cyc(0, 0, 0, 1, 32'h900, 0, 0, 0, 1, "ret_c");
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      int p;
      p  = $urandom_range(0, 99);
      ra = $urandom();
      if (p < 3) begin
        @(negedge clk);
        do_reset("rand_reset");
      end else begin
        cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
            ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ra[3:0]) : ra,
            $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, "rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised next-generation program counter for the CPU front end.
- Generalises the single-register PC with the following additions:
  - configurable address width, reset vector and instruction stride;
  - internal sequential increment;
  - prioritised redirect, trap and trap-return;
  - sticky halt state with explicit resume;
  - saved exception PC (EPC).
- Feeds fetch with currAddr; receives redirects from decode/execute.

Parameters:
- ADDR_W, 32, PC and address width in bits.
- RESET_VEC, 32'h0000_0000, PC value loaded on reset (truncated to ADDR_W).
- TRAP_VEC, 32'h0000_0100, PC value loaded on trap.
- INSTR_BYTES, 4, sequential increment; power of two ≥1.
- RAS_DEPTH, 4, return-address-stack entries (used only with PC_RAS_EN); power of two ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- halt  in  1  enter HALTED state.
- resume  in  1  leave HALTED state.
- stallPC  in  1  hold PC this cycle.
- redirectValid  in  1  take redirectAddr as next PC.
- redirectAddr  in  ADDR_W  branch/jump target.
- trap  in  1  exception/interrupt request.
- eret  in  1  return from trap to epc.
- call  in  1  qualifies redirect as call (PC_RAS_EN only).
- ret  in  1  qualifies redirect as return (PC_RAS_EN only).
- currAddr  out  ADDR_W  current PC.
- epc  out  ADDR_W  saved trap PC.
- halted  out  1  high in HALTED state.

Behaviour:
- Reset (rst=0, async): currAddr=RESET_VEC, epc=0, halted=0, state=RUN, RAS empty. All registers update only on rising clk while rst=1.
- State RUN, per-cycle priority, highest first:
  1. trap: currAddr←TRAP_VEC, epc←currAddr.
  2. eret: currAddr←epc.
  3. redirectValid: currAddr←redirectAddr, low log2(INSTR_BYTES) bits forced to 0.
  4. halt: hold currAddr, state←HALTED.
  5. stallPC: hold.
  6. Otherwise: currAddr←currAddr+INSTR_BYTES.
- Rules that apply across the priority list:
  - Trap and eret override stallPC and halt.
  - redirectValid overrides halt and stall in the same cycle; halt is not taken that cycle.
- State HALTED:
  - currAddr held; halted=1.
  - trap: TRAP_VEC load, epc capture, state←RUN.
  - resume (no trap): state←RUN, PC unchanged that cycle; increments from the next cycle.
  - redirect, eret and stall ignored.
  - halt and resume both high: resume wins.
- Latency:
  - All changes visible on currAddr one clk after the request cycle.
  - halted asserts one cycle after halt is sampled.
- Arithmetic: increment and all loads are modulo 2^ADDR_W. Example: ADDR_W=32, 32'hFFFF_FFFC+4 → 0.
- trap and eret both high: trap wins; epc←currAddr.
- Reset mid-stall, mid-halt or mid-trap: immediate return to reset values.

Optional Feature:
- Macro: PC_RAS_EN.
- With PC_RAS_EN, a circular return address stack of RAS_DEPTH entries is present:
  - redirectValid&call: push currAddr+INSTR_BYTES.
  - redirectValid&ret, stack non-empty: target = popped entry (redirectAddr ignored).
  - redirectValid&ret, stack empty: use redirectAddr.
  - Push when full: overwrite oldest entry; count saturates at RAS_DEPTH.
  - call&ret together: pop then push (net count unchanged).
  - Trap, eret and reset do not touch the stack, except reset, which empties it.
- Without PC_RAS_EN: call/ret ignored, no stack storage, redirects always use redirectAddr.

Decomposition:
- Package pc_pkg:
  - pc_state_e enum {RUN, HALTED};
  - addr_t typedef (logic [ADDR_W-1:0], default width);
  - function aligning an address to INSTR_BYTES.
- One natural sub-module: pc_ras (pointer, count, storage, push/pop), instantiated only under PC_RAS_EN.

Test Plan:
- Reset then 3 free cycles → currAddr 0, 4, 8, 12; halted=0; epc=0.
- At PC=0x20, stallPC 2 cycles, then redirectValid redirectAddr=0x103 → PC holds 0x20, 0x20, then 0x100.
- At PC=0x40, halt → halted=1; PC stays 0x40 for 5 cycles; resume → next PC 0x40, then 0x44.
- At PC=0x80 with stallPC=1 and trap=1 → PC=0x100, epc=0x80; eret 2 cycles later → PC=0x80.
- PC=0xFFFF_FFFC, free run → wraps to 0x0. Assert rst low mid-halt → immediate RESET_VEC and halted=0.
- PC_RAS_EN, RAS_DEPTH=4:
  - 5 calls from PC 0x0 (redirect to 0x200 each), then 5 rets with redirectAddr=0x500 → rets 1–4 return the 4 newest pushed addresses, newest first; ret 5 → 0x500.
